pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Parametrised program-counter sequencer for the model computer: advances an AW-bit
//   address by a programmable step, either single-stepped or free-running at two rates.
//   Supports direct load, an explicit stop, and a trace register holding the previous address.
//   Sits between the front-panel controls and instruction memory; fully synchronous to clk.
// PARAMETERS
//   AW        8           address/step width
//   DIV_SLOW  50_000_000  clk cycles per advance in RUN_SLOW (1 s at 50 MHz)
//   DIV_FAST  500_000     clk cycles per advance in RUN_FAST (10 ms at 50 MHz)
//   DVW       $clog2(DIV_SLOW) (localparam)  divider counter width
// PORTS
//   clk         in   1    clock
//   rst         in   1    reset, asynchronous, active-high
//   next_i      in   1    single-step request (rising edge acts)
//   run_i       in   1    start slow run (rising edge acts)
//   speedrun_i  in   1    start fast run (rising edge acts)
//   stop_i      in   1    stop run (rising edge acts)
//   load_i      in   1    level: force pc to load_val
//   load_val    in   AW   load address
//   step        in   AW   increment per advance
//   pc_o        out  AW   current address
//   prev_o      out  AW   address before the most recent advance/load
//   running_o   out  1    state != IDLE
//   fast_o      out  1    state == RUN_FAST
//   tick_o      out  1    1-cycle pulse on every advance (step or timed)
// BEHAVIOUR
//   - Control inputs are synchronous to clk, already synchronised/debounced upstream.
//   - Edge detect: one delay flop per control input, reset to 1, so an input held high
//     through reset release does not fire. edge = in & ~in_d.
//   - Reset: pc_o=0, prev_o=0, running_o=0, fast_o=0, tick_o=0, state=IDLE, divider=0.
//   - States IDLE, RUN_SLOW, RUN_FAST. Per-cycle priority, highest first:
//     1 load_i high: pc<=load_val, prev<=pc, divider<=0, no tick, state unchanged.
//     2 stop edge: state<=IDLE, divider<=0.
//     3 next edge, state IDLE: advance (pc<=pc+step, prev<=pc, tick). Ignored while running.
//     4 speedrun edge: state<=RUN_FAST, divider<=0 (also from RUN_SLOW).
//     5 run edge: state<=RUN_SLOW, divider<=0 (also from RUN_FAST).
//     6 running: divider counts 0..N-1, N=DIV_SLOW or DIV_FAST; at N-1 -> divider<=0, advance.
//   - Advance: modulo-2^AW add, wraps silently (0xFF+0x02 -> 0x01 at AW=8); step=0 advances
//     (tick pulses) with pc unchanged.
//   - Latency: an action is registered on the clk edge at which its input edge is sampled;
//     outputs are visible the following cycle. First timed advance lands N cycles after
//     the start edge.
//   - Lower-priority edges arriving in the same cycle are dropped, not queued.
//   - Load held during RUN keeps divider at 0; run resumes, full N cycles after load_i falls.
//   - Mid-operation reset returns to reset values immediately (async).
// CONFIGURATION
//   PC_SEQ_BREAKPOINT_EN defined: adds ports bp_en (in,1), bp_addr (in,AW), bp_hit_o (out,1).
//     A timed advance whose new pc equals bp_addr while bp_en=1 forces state<=IDLE on the
//     same edge the pc updates; bp_hit_o pulses 1 cycle. Single-step and load never trigger.
//   Undefined: those ports absent; runs continue until stop_i or load.
// STRUCTURE
//   Package pc_seq_pkg: state enum {IDLE, RUN_SLOW, RUN_FAST}, 2-bit encoding constants.
//   Sub-module pc_tick_div: DVW-bit divider with clear, terminal count select, tick out.
//   Edge detectors and advance adder inline in pc_sequencer.
// TESTING (bench: AW=8, DIV_SLOW=4, DIV_FAST=2)
//   - Reset with next_i held high, release, keep high -> no advance; pc_o=0.
//   - step=3, three next edges in IDLE -> pc_o 3,6,9; prev_o 6; tick_o 3 single pulses.
//   - step=1, run edge -> pc increments every 4 cycles; speedrun edge -> every 2; stop -> halts.
//   - load_val=0xFE, load pulse, step=3, next edge -> pc_o=0x01 (wrap), prev_o=0xFE.
//   - run and load_i same cycle -> pc=load_val, state IDLE (run edge dropped).
//   - With PC_SEQ_BREAKPOINT_EN, bp_addr=0x08, step=2, run from 0 -> stops at 0x08, bp_hit_o 1 pulse.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared state encoding for the program-counter sequencer.
package pc_seq_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN_SLOW = 2'd1;
  localparam logic [1:0] ST_RUN_FAST = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    RUN_SLOW = ST_RUN_SLOW,
    RUN_FAST = ST_RUN_FAST
  } pc_state_e;

endpackage

// File: rtl/pc_tick_div.sv
// Rate divider: counts 0..N-1 while enabled, N selected between slow and fast terminal counts.
module pc_tick_div #(
  parameter int unsigned DVW      = 2,
  parameter int unsigned DIV_SLOW = 4,
  parameter int unsigned DIV_FAST = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_fast,
  output logic o_last_c
);

  logic [DVW-1:0] r_cnt;
  logic [DVW-1:0] w_last_val;

  assign w_last_val = i_fast ? DVW'(DIV_FAST - 1) : DVW'(DIV_SLOW - 1);
  assign o_last_c   = (r_cnt == w_last_val);

  // Clear wins over counting; terminal count wraps back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_last_c ? '0 : r_cnt + DVW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: single-step, slow/fast timed run, load, stop, trace of previous pc.
// Optional breakpoint on timed advances when PC_SEQ_BREAKPOINT_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned AW       = 8,
  parameter int unsigned DIV_SLOW = 50_000_000,
  parameter int unsigned DIV_FAST = 500_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          next_i,
  input  logic          run_i,
  input  logic          speedrun_i,
  input  logic          stop_i,
  input  logic          load_i,
  input  logic [AW-1:0] load_val,
  input  logic [AW-1:0] step,
  output logic [AW-1:0] pc_o,
  output logic [AW-1:0] prev_o,
  output logic          running_o,
  output logic          fast_o,
  output logic          tick_o
`ifdef PC_SEQ_BREAKPOINT_EN
  ,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  output logic          bp_hit_o
`endif
);

  localparam int unsigned DVW = $clog2(DIV_SLOW);

  pc_state_e     r_state, w_state_nxt;
  logic          r_running, r_fast, r_tick;
  logic [AW-1:0] r_pc, r_prev;
  logic [AW-1:0] w_pc_nxt, w_prev_nxt, w_adv;
  logic          w_tick_nxt;
  logic          r_next_d, r_run_d, r_speed_d, r_stop_d;
  logic          w_next_edge, w_run_edge, w_speed_edge, w_stop_edge;
  logic          w_div_clr, w_div_en, w_div_last;
  logic          w_step_adv, w_timed_adv, w_bp_trig;

  // Delay flops reset high so a control held through reset release does not fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_next_d  <= 1'b1;
      r_run_d   <= 1'b1;
      r_speed_d <= 1'b1;
      r_stop_d  <= 1'b1;
    end else begin
      r_next_d  <= next_i;
      r_run_d   <= run_i;
      r_speed_d <= speedrun_i;
      r_stop_d  <= stop_i;
    end
  end

  assign w_next_edge  = next_i & ~r_next_d;
  assign w_run_edge   = run_i & ~r_run_d;
  assign w_speed_edge = speedrun_i & ~r_speed_d;
  assign w_stop_edge  = stop_i & ~r_stop_d;

  assign w_adv       = r_pc + step;
  assign w_div_clr   = load_i | w_stop_edge | w_speed_edge | w_run_edge;
  assign w_div_en    = (r_state != IDLE) & ~w_div_clr;
  assign w_step_adv  = ~load_i & ~w_stop_edge & w_next_edge & (r_state == IDLE);
  assign w_timed_adv = w_div_en & w_div_last;

`ifdef PC_SEQ_BREAKPOINT_EN
  assign w_bp_trig = bp_en & (w_adv == bp_addr);
`else
  assign w_bp_trig = 1'b0;
`endif

  pc_tick_div #(
    .DVW      (DVW),
    .DIV_SLOW (DIV_SLOW),
    .DIV_FAST (DIV_FAST)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_div_clr),
    .i_en     (w_div_en),
    .i_fast   (r_state == RUN_FAST),
    .o_last_c (w_div_last)
  );

  // State register; status outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_fast    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt != IDLE);
      r_fast    <= (w_state_nxt == RUN_FAST);
    end
  end

  // Next state: load > stop > step > speedrun > run > timed advance (breakpoint).
  always_comb begin
    w_state_nxt = r_state;
    if (load_i)                      w_state_nxt = r_state;
    else if (w_stop_edge)            w_state_nxt = IDLE;
    else if (w_step_adv)             w_state_nxt = IDLE;
    else if (w_speed_edge)           w_state_nxt = RUN_FAST;
    else if (w_run_edge)             w_state_nxt = RUN_SLOW;
    else if (w_timed_adv && w_bp_trig) w_state_nxt = IDLE;
  end

  // Datapath next values.
  always_comb begin
    w_pc_nxt   = r_pc;
    w_prev_nxt = r_prev;
    w_tick_nxt = 1'b0;
    if (load_i) begin
      w_pc_nxt   = load_val;
      w_prev_nxt = r_pc;
    end else if (w_step_adv || w_timed_adv) begin
      w_pc_nxt   = w_adv;
      w_prev_nxt = r_pc;
      w_tick_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= '0;
      r_prev <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_prev <= w_prev_nxt;
      r_tick <= w_tick_nxt;
    end
  end

`ifdef PC_SEQ_BREAKPOINT_EN
  logic r_bp_hit;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_bp_hit <= 1'b0;
    else     r_bp_hit <= w_timed_adv & w_bp_trig;
  end
  assign bp_hit_o = r_bp_hit;
`endif

  assign pc_o      = r_pc;
  assign prev_o    = r_prev;
  assign running_o = r_running;
  assign fast_o    = r_fast;
  assign tick_o    = r_tick;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (AW=8, DIV_SLOW=4, DIV_FAST=2); breakpoint steps need PC_SEQ_BREAKPOINT_EN.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       next_i, run_i, speedrun_i, stop_i, load_i;
  logic [7:0] load_val, step;
  logic [7:0] pc_o, prev_o;
  logic       running_o, fast_o, tick_o;
`ifdef PC_SEQ_BREAKPOINT_EN
  logic       bp_en;
  logic [7:0] bp_addr;
  logic       bp_hit_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .AW       (8),
    .DIV_SLOW (4),
    .DIV_FAST (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .next_i     (next_i),
    .run_i      (run_i),
    .speedrun_i (speedrun_i),
    .stop_i     (stop_i),
    .load_i     (load_i),
    .load_val   (load_val),
    .step       (step),
    .pc_o       (pc_o),
    .prev_o     (prev_o),
    .running_o  (running_o),
    .fast_o     (fast_o),
    .tick_o     (tick_o)
`ifdef PC_SEQ_BREAKPOINT_EN
    ,
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .bp_hit_o   (bp_hit_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; next_i = 1'b1; run_i = 1'b0; speedrun_i = 1'b0; stop_i = 1'b0;
    load_i = 1'b0; load_val = 8'h00; step = 8'h00;
`ifdef PC_SEQ_BREAKPOINT_EN
    bp_en = 1'b0; bp_addr = 8'h00;
`endif
    cyc(2);
    chk("rst_pc", pc_o, 0);
    chk("rst_prev", prev_o, 0);
    chk("rst_running", running_o, 0);
    chk("rst_fast", fast_o, 0);
    chk("rst_tick", tick_o, 0);

    // next_i held high through reset release must not advance
    rst = 1'b0; step = 8'd3;
    cyc(3);
    chk("hold_pc", pc_o, 0);
    chk("hold_tick", tick_o, 0);
    next_i = 1'b0;
    cyc(1);

    // three single steps of 3
    next_i = 1'b1; cyc(1);
    chk("step1_pc", pc_o, 8'd3);
    chk("step1_tick", tick_o, 1);
    next_i = 1'b0; cyc(1);
    chk("step1_tick_low", tick_o, 0);
    next_i = 1'b1; cyc(1);
    chk("step2_pc", pc_o, 8'd6);
    chk("step2_tick", tick_o, 1);
    next_i = 1'b0; cyc(1);
    chk("step2_tick_low", tick_o, 0);
    next_i = 1'b1; cyc(1);
    chk("step3_pc", pc_o, 8'd9);
    chk("step3_prev", prev_o, 8'd6);
    chk("step3_tick", tick_o, 1);
    next_i = 1'b0; cyc(1);
    chk("step3_tick_low", tick_o, 0);

    // slow run, step 1: advance every 4 cycles
    step = 8'd1;
    run_i = 1'b1; cyc(1);
    run_i = 1'b0;
    chk("run_running", running_o, 1);
    chk("run_fast", fast_o, 0);
    cyc(3);
    chk("run_pre_pc", pc_o, 8'd9);
    chk("run_pre_tick", tick_o, 0);
    cyc(1);
    chk("run_adv1_pc", pc_o, 8'd10);
    chk("run_adv1_tick", tick_o, 1);
    cyc(4);
    chk("run_adv2_pc", pc_o, 8'd11);

    // switch to fast run: advance every 2 cycles
    speedrun_i = 1'b1; cyc(1);
    speedrun_i = 1'b0;
    chk("fast_flag", fast_o, 1);
    chk("fast_start_pc", pc_o, 8'd11);
    cyc(2);
    chk("fast_adv1_pc", pc_o, 8'd12);
    chk("fast_adv1_tick", tick_o, 1);
    cyc(2);
    chk("fast_adv2_pc", pc_o, 8'd13);

    // stop halts the run
    stop_i = 1'b1; cyc(1);
    stop_i = 1'b0;
    chk("stop_running", running_o, 0);
    chk("stop_fast", fast_o, 0);
    cyc(5);
    chk("stop_pc", pc_o, 8'd13);

    // load then step across the wrap boundary
    load_val = 8'hFE; load_i = 1'b1; cyc(1);
    load_i = 1'b0;
    chk("load_pc", pc_o, 8'hFE);
    chk("load_prev", prev_o, 8'd13);
    chk("load_tick", tick_o, 0);
    step = 8'd3;
    next_i = 1'b1; cyc(1);
    next_i = 1'b0;
    chk("wrap_pc", pc_o, 8'h01);
    chk("wrap_prev", prev_o, 8'hFE);
    cyc(1);

    // run edge coincident with load is dropped
    load_val = 8'h40; load_i = 1'b1; run_i = 1'b1; cyc(1);
    load_i = 1'b0; run_i = 1'b0;
    chk("loadrun_pc", pc_o, 8'h40);
    chk("loadrun_running", running_o, 0);
    cyc(5);
    chk("loadrun_pc_after", pc_o, 8'h40);

    // step of zero still ticks
    step = 8'd0;
    next_i = 1'b1; cyc(1);
    next_i = 1'b0;
    chk("step0_pc", pc_o, 8'h40);
    chk("step0_tick", tick_o, 1);
    cyc(1);

`ifdef PC_SEQ_BREAKPOINT_EN
    // breakpoint at 0x08 with step 2 from 0
    bp_en = 1'b1; bp_addr = 8'h08; step = 8'd2;
    load_val = 8'h00; load_i = 1'b1; cyc(1);
    load_i = 1'b0;
    run_i = 1'b1; cyc(1);
    run_i = 1'b0;
    cyc(15);
    chk("bp_pre_pc", pc_o, 8'h06);
    chk("bp_pre_hit", bp_hit_o, 0);
    cyc(1);
    chk("bp_pc", pc_o, 8'h08);
    chk("bp_hit", bp_hit_o, 1);
    chk("bp_running", running_o, 0);
    cyc(1);
    chk("bp_hit_low", bp_hit_o, 0);
    cyc(8);
    chk("bp_pc_hold", pc_o, 8'h08);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
